arbiter_multicore_drain: RTL

Parametrised multi-core drain arbiter. It empties the per-core NeuRRAM I/O FIFOs into a single output word stream, visiting the selected cores in ascending index order. For each selected core it forwards a programmable number of words, optionally preceded by a header word. It sits between the N per-core first-word-fall-through FIFOs and the host-side CDC/pipe-out FIFO. It adds start/done transaction control, 16-bit word counts, per-core headers, abort and a registered valid/ready output stage.

---
 rtl/arbiter_multicore_drain.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/arbiter_multicore_drain.sv
// Multi-core drain arbiter: walks the selected core FIFOs in ascending order,
// forwarding an optional header plus num_words payload words per core into a
// single registered valid/ready output stage.
module arbiter_multicore_drain #(
  parameter int N_CORES   = 8,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int HEADER_EN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_CORES-1:0]          core_select,
  input  logic [CNT_W-1:0]            num_words,
  input  logic [N_CORES*DATA_W-1:0]   in_dout,
  input  logic [N_CORES-1:0]          in_empty,
  output logic [N_CORES-1:0]          in_rd_en,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  // One extra code so idx can point one past the last core (end of scan).
  localparam int IDX_W = $clog2(N_CORES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_HEADER,
    S_XFER,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_CORES-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q, valid_d;
  logic                busy_q;
  logic                done_q, done_d;

  logic                cur_sel;
  logic                cur_empty;
  logic [DATA_W-1:0]   cur_data;
  logic [DATA_W-1:0]   hdr;
  logic [DATA_W-1:0]   load_word;
  logic                load;
  logic                pop;
  logic                kill;
  logic                stage_free;

  assign stage_free = ~out_valid_q | out_ready;
  assign kill       = abort & (state_q != S_IDLE);

  // Select the FIFO signals of the core currently addressed by idx.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cur_sel   = 1'b0;
    cur_empty = 1'b1;
    cur_data  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_sel   = sel_q[k];
        cur_empty = in_empty[k];
        cur_data  = in_dout[k*DATA_W +: DATA_W];
      end
    end
  end

  // Header word: A5 marker, core index, zero padding, payload length.
  generate
    if (HEADER_EN != 0) begin : g_hdr
      always_comb begin
        hdr                   = '0;
        hdr[DATA_W-1 -: 8]    = 8'hA5;
        hdr[DATA_W-9 -: 8]    = 8'(idx_q);
        hdr[CNT_W-1:0]        = num_q;
      end
    end else begin : g_no_hdr
      assign hdr = '0;
    end
  endgenerate

  // Next-state, pop and output-stage load decisions.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    num_d     = num_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    load      = 1'b0;
    load_word = '0;
    pop       = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          sel_d   = core_select;
          num_d   = num_words;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx_q == IDX_W'(N_CORES)) begin
          state_d = S_DONE;
        end else if (!cur_sel || num_q == '0) begin
          idx_d = idx_q + 1'b1;
        end else begin
          wcnt_d  = '0;
          state_d = (HEADER_EN != 0) ? S_HEADER : S_XFER;
        end
      end
      S_HEADER: begin
        if (stage_free) begin
          load      = 1'b1;
          load_word = hdr;
          state_d   = S_XFER;
        end
      end
      S_XFER: begin
        if (wcnt_q == num_q) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCAN;
        end else if (!cur_empty && stage_free) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_word = cur_data;
          wcnt_d    = wcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!out_valid_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: back to idle, nothing popped or loaded.
    if (kill) begin
      state_d = S_IDLE;
      pop     = 1'b0;
      load    = 1'b0;
      done_d  = 1'b0;
    end

    // Output valid: drop on abort, set on load, clear on acceptance.
    if (kill)           valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    else                valid_d = out_valid_q;
  end

  // Decode the pop toward the addressed core only.
  always_comb begin
    in_rd_en = '0;
    for (int k = 0; k < N_CORES; k++) begin
      in_rd_en[k] = pop & (idx_q == IDX_W'(k));
    end
  end

  // State, latched request, counters and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= valid_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      if (load) out_data_q <= load_word;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
